// File: rtl/isqrt_iter_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_iter_fsm
//  Description : Iterative unsigned integer square root, y = floor(sqrt(x)).
//                Produces one result bit per clock using the classic
//                restoring digit-by-digit method, MSB operand pair first.
//                Fixed latency of N_BITS/2+1 cycles from accepted request to
//                the one-cycle y_vld pulse, so parallel instances with equal
//                N_BITS always complete in lockstep.
//                Optional macro ISQRT_ITER_PROTOCOL_CHECK_EN compiles in
//                simulation-only protocol checks (dropped request, stretched
//                y_vld, X/Z on the handshake signals).
//  Revision    : 1.0 - initial release
// ============================================================================
module isqrt_iter_fsm #(
    parameter int N_BITS = 32   // even and >= 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  x_vld,
    input  logic [N_BITS-1:0]     x,
    output logic                  y_vld,
    output logic [N_BITS/2-1:0]   y,
    output logic                  busy
);

    localparam int HALF  = N_BITS / 2;
    localparam int REM_W = HALF + 2;
    localparam int CNT_W = $clog2(HALF) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(HALF - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [REM_W-1:0]    rem_q;
    logic [REM_W-1:0]    rem_d;
    logic [HALF-1:0]     root_q;
    logic [HALF-1:0]     root_d;
    logic [N_BITS-1:0]   x_sh_q;
    logic [HALF-1:0]     y_q;
    logic                y_vld_q;
    logic                busy_q;

    logic [REM_W-1:0]    iter_t;
    logic [REM_W-1:0]    iter_trial;
    logic                iter_ge;

    // One restoring iteration: bring down the next operand pair and try to
    // subtract {root,01}. The remainder never exceeds 2*root, so truncating
    // the shifted remainder to REM_W bits loses nothing.
    always_comb begin
        iter_t     = REM_W'({rem_q, x_sh_q[N_BITS-1 -: 2]});
        iter_trial = {root_q, 2'b01};
        iter_ge    = (iter_t >= iter_trial);
        rem_d      = iter_ge ? (iter_t - iter_trial) : iter_t;
        root_d     = HALF'({root_q, iter_ge});
    end

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            x_sh_q  <= '0;
            y_q     <= '0;
            y_vld_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            y_vld_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (x_vld) begin
                        x_sh_q  <= x;
                        rem_q   <= '0;
                        root_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CALC;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    // Requests arriving here are ignored; the captured x_sh is the only operand.
                    x_sh_q <= x_sh_q << 2;
                    rem_q  <= rem_d;
                    root_q <= root_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        y_q     <= root_d;
                        y_vld_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign y_vld = y_vld_q;
    assign y     = y_q;
    assign busy  = busy_q;

`ifdef ISQRT_ITER_PROTOCOL_CHECK_EN
    logic chk_y_vld_prev_q;

    // Simulation-only handshake monitors.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_y_vld_prev_q <= 1'b0;
        end else begin
            chk_y_vld_prev_q <= y_vld_q;
            if ($isunknown(x_vld) || $isunknown(y_vld_q))
                $error("isqrt_iter_fsm: x_vld or y_vld is X/Z");
            else begin
                if (x_vld && busy_q)
                    $error("isqrt_iter_fsm: request dropped while busy");
                if (y_vld_q && chk_y_vld_prev_q)
                    $error("isqrt_iter_fsm: y_vld high two consecutive cycles");
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_isqrt_iter_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_isqrt_iter_fsm
//  Description : Self-checking bench for isqrt_iter_fsm (N_BITS=32 and 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_isqrt_iter_fsm;

    localparam int NRAND = 2500;

    logic        clk = 1'b0;
    logic        rst;
    logic        x_vld;
    logic [31:0] x;
    logic        y_vld;
    logic [15:0] y;
    logic        busy;
    logic        x8_vld;
    logic [7:0]  x8;
    logic        y8_vld;
    logic [3:0]  y8;
    logic        busy8;

    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    isqrt_iter_fsm #(.N_BITS(32)) dut (
        .clk(clk), .rst(rst), .x_vld(x_vld), .x(x),
        .y_vld(y_vld), .y(y), .busy(busy)
    );

    isqrt_iter_fsm #(.N_BITS(8)) dut8 (
        .clk(clk), .rst(rst), .x_vld(x8_vld), .x(x8),
        .y_vld(y8_vld), .y(y8), .busy(busy8)
    );

    typedef struct {
        logic [31:0] x;
        logic [15:0] y;
    } vec_t;

    typedef struct {
        int unsigned due;
        logic [15:0] y;
    } exp_t;

    // Reference: largest r with r*r <= v, found by bisection.
    function automatic longint unsigned isqrt_ref(input longint unsigned v);
        longint unsigned lo = 0;
        longint unsigned hi = 64'd1 << 32;
        longint unsigned mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= v) lo = mid;
            else                hi = mid;
        end
        return lo;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    // Issue one request on the 32-bit DUT and wait for its result.
    task automatic run_one(input logic [31:0] xv, output logic [15:0] got, output int lat);
        int unsigned t0;
        bit found = 0;
        @(posedge clk); #1;
        x = xv; x_vld = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        x_vld = 1'b0; x = $urandom;
        got = 'x; lat = -1;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (y_vld) begin found = 1; got = y; lat = int'(cyc - t0); end
        end
    endtask

    task automatic run_one8(input logic [7:0] xv, output logic [3:0] got, output int lat);
        int unsigned t0;
        bit found = 0;
        @(posedge clk); #1;
        x8 = xv; x8_vld = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        x8_vld = 1'b0; x8 = 8'($urandom);
        got = 'x; lat = -1;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (y8_vld) begin found = 1; got = y8; lat = int'(cyc - t0); end
        end
    endtask

    function automatic logic [31:0] pick_x();
        longint unsigned s;
        longint unsigned v;
        case ($urandom % 4)
            0: v = $urandom;
            1: v = $urandom % 1024;
            2: begin
                s = $urandom % 65536;
                v = s * s + ($urandom % 3);
                if (v > 0 && ($urandom % 2) == 0) v = v - 2;
                v = v & 64'hFFFF_FFFF;
            end
            default: v = 64'hFFFF_FFFF - ($urandom % 1000);
        endcase
        return v[31:0];
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[10];
        logic [15:0] got;
        logic [3:0]  got8;
        int          lat;
        exp_t        q[$];
        int unsigned last_due;
        int unsigned limit;
        int          issued;
        logic [31:0] xv;
        bit          go;
        bit          exp_v;
        bit          exp_busy;

        vecs[0] = '{32'd15,          16'd3};
        vecs[1] = '{32'd16,          16'd4};
        vecs[2] = '{32'hFFFF_FFFF,   16'hFFFF};
        vecs[3] = '{32'h4000_0000,   16'h8000};
        vecs[4] = '{32'd0,           16'd0};
        vecs[5] = '{32'd1,           16'd1};
        vecs[6] = '{32'hFFFE_0001,   16'hFFFF};
        vecs[7] = '{32'hFFFE_0000,   16'hFFFE};
        vecs[8] = '{32'd99,          16'd9};
        vecs[9] = '{32'd1_000_000,   16'd1000};

        rst = 1'b1; x_vld = 1'b0; x = '0; x8_vld = 1'b0; x8 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset y_vld", y_vld, 0);
        chk("reset y",     y,     0);
        chk("reset busy",  busy,  0);
        chk("reset y8_vld", y8_vld, 0);
        chk("reset busy8",  busy8,  0);

        // x=0: busy for cycles 1..16, single y_vld in cycle 17.
        @(posedge clk); #1;
        x = 32'd0; x_vld = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin x_vld = 1'b0; x = $urandom; end
            @(negedge clk);
            chk($sformatf("zero busy k=%0d", k), busy, (k <= 16));
            chk($sformatf("zero y_vld k=%0d", k), y_vld, (k == 17));
            if (k == 17) chk("zero y", y, 0);
        end

        foreach (vecs[i]) begin
            run_one(vecs[i].x, got, lat);
            chk($sformatf("vec%0d y x=%0h", i, vecs[i].x), got, vecs[i].y);
            chk($sformatf("vec%0d latency", i), lat, 17);
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("y held while idle", y, vecs[9].y);

        // Back-to-back: 100 then 81 presented in the y_vld cycle.
        @(posedge clk); #1;
        x = 32'd100; x_vld = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            @(posedge clk); #1;
            x_vld = 1'b0; x = $urandom;
            if (k == 17) begin x = 32'd81; x_vld = 1'b1; end
            @(negedge clk);
            chk($sformatf("b2b y_vld k=%0d", k), y_vld, (k == 17 || k == 34));
            if (k == 17) chk("b2b y first", y, 10);
            if (k == 25) chk("b2b y held in CALC", y, 10);
            if (k == 34) chk("b2b y second", y, 9);
        end

        // Request during busy is dropped.
        @(posedge clk); #1;
        x = 32'd49; x_vld = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            x_vld = 1'b0; x = $urandom;
            if (k == 5) begin x = 32'd4; x_vld = 1'b1; end
            @(negedge clk);
            chk($sformatf("drop y_vld k=%0d", k), y_vld, (k == 17));
            if (k == 17) chk("drop y", y, 7);
        end

        // Reset mid-operation abandons the result.
        @(posedge clk); #1;
        x = 32'd1000; x_vld = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin x_vld = 1'b0; x = $urandom; end
            if (k == 8) rst = 1'b1;
            if (k == 9) rst = 1'b0;
            @(negedge clk);
            chk($sformatf("rst y_vld k=%0d", k), y_vld, 0);
            if (k >= 9) begin
                chk($sformatf("rst y k=%0d", k), y, 0);
                chk($sformatf("rst busy k=%0d", k), busy, 0);
            end
        end
        run_one(32'd9, got, lat);
        chk("after rst y", got, 3);
        chk("after rst latency", lat, 17);

        // Random traffic against the reference model, including back-to-back.
        issued   = 0;
        last_due = cyc;
        limit    = cyc + 80000;
        while ((issued < NRAND || q.size() > 0) && cyc < limit) begin
            @(posedge clk); #1;
            x_vld = 1'b0; x = $urandom;
            if (issued < NRAND && cyc >= last_due) begin
                go = (cyc == last_due) ? (($urandom % 2) == 0) : (($urandom % 3) == 0);
                if (go) begin
                    xv = pick_x();
                    x = xv; x_vld = 1'b1;
                    q.push_back('{cyc + 17, 16'(isqrt_ref({32'd0, xv}))});
                    last_due = cyc + 17;
                    issued++;
                end
            end
            @(negedge clk);
            exp_v    = (q.size() > 0) && (q[0].due == cyc);
            exp_busy = (q.size() > 0) && (cyc > q[$].due - 17) && (cyc < q[$].due);
            chk("rand y_vld", y_vld, exp_v);
            chk("rand busy", busy, exp_busy);
            if (exp_v) begin
                chk("rand y", y, q[0].y);
                void'(q.pop_front());
            end
        end
        x_vld = 1'b0;
        if (issued < NRAND || q.size() > 0) timeout_fail("rand completion");

        // Exhaustive N_BITS=8.
        for (int v = 0; v < 256; v++) begin
            run_one8(8'(v), got8, lat);
            chk($sformatf("n8 y x=%0d", v), got8, isqrt_ref(v));
            chk($sformatf("n8 latency x=%0d", v), lat, 5);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
